jzjpcc_hazard_controller: RTL and testbench

- Pipeline sequencer for the decode→execute boundary of the pipelined core.
- Decides each cycle whether PC/decode advance, stall, or flush:
  - load-use stalls,
  - taken-branch flushes with a configurable wrong-path shadow.
- Produces registered forwarding selects that travel with the instruction into execute alongside the execute-stage interface bundle.
- Keeps saturating stall/flush performance counters.

---
 rtl/jzjpcc_hazard_controller.sv | 182 ++++++++++++++++++
 tb/tb_jzjpcc_hazard_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_hazard_controller.sv
// jzjpcc_hazard_controller
// Decode/execute boundary sequencer for the pipelined core. Each cycle it
// decides whether fetch/decode advance, stall for a load-use hazard, or get
// flushed after a taken branch. It also registers the operand forwarding
// selects for the instruction entering execute and keeps saturating
// stall/flush performance counters.
module jzjpcc_hazard_controller #(
    parameter int PC_MAX_B      = 31,
    parameter int BRANCH_SHADOW = 1,
    parameter int PERF_W        = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [4:0]          decodeRs1Addr,
    input  logic [4:0]          decodeRs2Addr,
    input  logic                decodeRs1Used,
    input  logic                decodeRs2Used,
    input  logic [4:0]          exRdAddr,
    input  logic                exRdWriteEnable,
    input  logic                exIsLoad,
    input  logic [4:0]          memRdAddr,
    input  logic                memRdWriteEnable,
    input  logic                branchTaken,
    input  logic [PC_MAX_B:2]   branchTarget,
    output logic                pcStall,
    output logic                pcLoad,
    output logic [PC_MAX_B:2]   pcNext,
    output logic                decodeStall,
    output logic                decodeFlush,
    output logic                executeFlush,
    output logic [1:0]          forwardRs1Sel,
    output logic [1:0]          forwardRs2Sel,
    output logic [PERF_W-1:0]   stallCount,
    output logic [PERF_W-1:0]   flushCount
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [1:0]        SHADOW_INIT = 2'(BRANCH_SHADOW - 1);
    localparam logic [PERF_W-1:0] PERF_ONE    = {{(PERF_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_MAX    = {PERF_W{1'b1}};

    localparam logic [1:0] SEL_REGFILE = 2'd0;
    localparam logic [1:0] SEL_MEM     = 2'd1;
    localparam logic [1:0] SEL_WB      = 2'd2;

    state_t              r_state;
    state_t              w_nextState;
    logic [1:0]          r_shadowCnt;
    logic [1:0]          w_nextShadowCnt;
    logic [1:0]          r_fwdRs1Sel;
    logic [1:0]          r_fwdRs2Sel;
    logic [PERF_W-1:0]   r_stallCount;
    logic [PERF_W-1:0]   r_flushCount;

    logic                w_hazRs1;
    logic                w_hazRs2;
    logic                w_loadUse;
    logic                w_advance;
    logic                w_stallEdge;
    logic                w_branchEdge;
    logic [1:0]          w_fwdRs1Sel;
    logic [1:0]          w_fwdRs2Sel;

    // Youngest producer wins: execute result beats memory result; x0 never forwards.
    function automatic logic [1:0] forwardSelect(
        input logic       used,
        input logic [4:0] rsAddr,
        input logic       exWe,
        input logic [4:0] exRd,
        input logic       memWe,
        input logic [4:0] memRd
    );
        logic [1:0] sel;
        sel = SEL_REGFILE;
        if (used && (rsAddr != 5'd0)) begin
            if (exWe && (exRd == rsAddr)) begin
                sel = SEL_MEM;
            end else if (memWe && (memRd == rsAddr)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    // Hazard detection and forward-select candidates for the decode instruction.
    always_comb begin
        w_hazRs1 = decodeRs1Used && (decodeRs1Addr != 5'd0) && exRdWriteEnable
                   && exIsLoad && (exRdAddr == decodeRs1Addr);
        w_hazRs2 = decodeRs2Used && (decodeRs2Addr != 5'd0) && exRdWriteEnable
                   && exIsLoad && (exRdAddr == decodeRs2Addr);
        w_loadUse = w_hazRs1 | w_hazRs2;
        w_fwdRs1Sel = forwardSelect(decodeRs1Used, decodeRs1Addr, exRdWriteEnable,
                                    exRdAddr, memRdWriteEnable, memRdAddr);
        w_fwdRs2Sel = forwardSelect(decodeRs2Used, decodeRs2Addr, exRdWriteEnable,
                                    exRdAddr, memRdWriteEnable, memRdAddr);
    end

    // Next-state and control outputs; a taken branch outranks a load-use stall.
    always_comb begin
        w_nextState     = r_state;
        w_nextShadowCnt = r_shadowCnt;
        pcStall         = 1'b0;
        pcLoad          = 1'b0;
        decodeStall     = 1'b0;
        decodeFlush     = 1'b0;
        executeFlush    = 1'b0;
        w_advance       = 1'b0;
        w_stallEdge     = 1'b0;
        w_branchEdge    = 1'b0;
        case (r_state)
            RUN: begin
                if (branchTaken) begin
                    pcLoad       = 1'b1;
                    decodeFlush  = 1'b1;
                    executeFlush = 1'b1;
                    w_branchEdge = 1'b1;
                    if (BRANCH_SHADOW > 1) begin
                        w_nextState     = FLUSH;
                        w_nextShadowCnt = SHADOW_INIT;
                    end
                end else if (w_loadUse) begin
                    pcStall      = 1'b1;
                    decodeStall  = 1'b1;
                    executeFlush = 1'b1;
                    w_stallEdge  = 1'b1;
                end else begin
                    w_advance = 1'b1;
                end
            end
            FLUSH: begin
                decodeFlush     = 1'b1;
                executeFlush    = 1'b1;
                w_nextShadowCnt = r_shadowCnt - 2'd1;
                if (r_shadowCnt <= 2'd1) begin
                    w_nextState = RUN;
                end
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    // State, forward selects and saturating perf counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= RUN;
            r_shadowCnt  <= 2'd0;
            r_fwdRs1Sel  <= SEL_REGFILE;
            r_fwdRs2Sel  <= SEL_REGFILE;
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            r_state     <= w_nextState;
            r_shadowCnt <= w_nextShadowCnt;
            if (w_advance) begin
                r_fwdRs1Sel <= w_fwdRs1Sel;
                r_fwdRs2Sel <= w_fwdRs2Sel;
            end else if (!w_stallEdge) begin
                r_fwdRs1Sel <= SEL_REGFILE;
                r_fwdRs2Sel <= SEL_REGFILE;
            end
            if (w_stallEdge && (r_stallCount != PERF_MAX)) begin
                r_stallCount <= r_stallCount + PERF_ONE;
            end
            if (w_branchEdge && (r_flushCount != PERF_MAX)) begin
                r_flushCount <= r_flushCount + PERF_ONE;
            end
        end
    end

    assign pcNext        = branchTarget;
    assign forwardRs1Sel = r_fwdRs1Sel;
    assign forwardRs2Sel = r_fwdRs2Sel;
    assign stallCount    = r_stallCount;
    assign flushCount    = r_flushCount;

endmodule

// File: tb/tb_jzjpcc_hazard_controller.sv
// Testbench for jzjpcc_hazard_controller: directed vectors, a behavioural
// reference model compared every cycle, and hand-computed literal checks.
module tb_jzjpcc_hazard_controller;

    localparam int PC_MAX_B      = 31;
    localparam int BRANCH_SHADOW = 3;
    localparam int PERF_W        = 4;
    localparam int PERF_SAT      = (1 << PERF_W) - 1;

    logic                clock;
    logic                reset;
    logic [4:0]          decodeRs1Addr;
    logic [4:0]          decodeRs2Addr;
    logic                decodeRs1Used;
    logic                decodeRs2Used;
    logic [4:0]          exRdAddr;
    logic                exRdWriteEnable;
    logic                exIsLoad;
    logic [4:0]          memRdAddr;
    logic                memRdWriteEnable;
    logic                branchTaken;
    logic [PC_MAX_B:2]   branchTarget;
    logic                pcStall;
    logic                pcLoad;
    logic [PC_MAX_B:2]   pcNext;
    logic                decodeStall;
    logic                decodeFlush;
    logic                executeFlush;
    logic [1:0]          forwardRs1Sel;
    logic [1:0]          forwardRs2Sel;
    logic [PERF_W-1:0]   stallCount;
    logic [PERF_W-1:0]   flushCount;

    int assertCount = 0;
    int errCount    = 0;

    jzjpcc_hazard_controller #(
        .PC_MAX_B      (PC_MAX_B),
        .BRANCH_SHADOW (BRANCH_SHADOW),
        .PERF_W        (PERF_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .decodeRs1Addr    (decodeRs1Addr),
        .decodeRs2Addr    (decodeRs2Addr),
        .decodeRs1Used    (decodeRs1Used),
        .decodeRs2Used    (decodeRs2Used),
        .exRdAddr         (exRdAddr),
        .exRdWriteEnable  (exRdWriteEnable),
        .exIsLoad         (exIsLoad),
        .memRdAddr        (memRdAddr),
        .memRdWriteEnable (memRdWriteEnable),
        .branchTaken      (branchTaken),
        .branchTarget     (branchTarget),
        .pcStall          (pcStall),
        .pcLoad           (pcLoad),
        .pcNext           (pcNext),
        .decodeStall      (decodeStall),
        .decodeFlush      (decodeFlush),
        .executeFlush     (executeFlush),
        .forwardRs1Sel    (forwardRs1Sel),
        .forwardRs2Sel    (forwardRs2Sel),
        .stallCount       (stallCount),
        .flushCount       (flushCount)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit   modelValid = 1'b0;
    int   flushLeft  = 0;
    int   mStall     = 0;
    int   mFlush     = 0;
    int   mSel1      = 0;
    int   mSel2      = 0;

    function automatic bit waitsOnLoad(input logic used, input logic [4:0] rs);
        return used && rs != 0 && exRdWriteEnable && exIsLoad && exRdAddr == rs;
    endfunction

    function automatic int producerOf(input logic used, input logic [4:0] rs);
        if (!used || rs == 0) return 0;
        if (exRdWriteEnable && exRdAddr == rs) return 1;
        if (memRdWriteEnable && memRdAddr == rs) return 2;
        return 0;
    endfunction

    function automatic bit modelLoadUse();
        return waitsOnLoad(decodeRs1Used, decodeRs1Addr) ||
               waitsOnLoad(decodeRs2Used, decodeRs2Addr);
    endfunction

    // Advance the model on every rising edge from the stable inputs.
    always @(posedge clock) begin
        if (reset) begin
            modelValid = 1'b1;
            flushLeft  = 0;
            mStall     = 0;
            mFlush     = 0;
            mSel1      = 0;
            mSel2      = 0;
        end else if (modelValid) begin
            if (flushLeft > 0) begin
                flushLeft = flushLeft - 1;
                mSel1 = 0;
                mSel2 = 0;
            end else if (branchTaken) begin
                flushLeft = BRANCH_SHADOW - 1;
                if (mFlush < PERF_SAT) mFlush = mFlush + 1;
                mSel1 = 0;
                mSel2 = 0;
            end else if (modelLoadUse()) begin
                if (mStall < PERF_SAT) mStall = mStall + 1;
            end else begin
                mSel1 = producerOf(decodeRs1Used, decodeRs1Addr);
                mSel2 = producerOf(decodeRs2Used, decodeRs2Addr);
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clock) begin
        if (modelValid) begin
            bit expLoad, expPcStall, expDecFlush, expExFlush;
            expLoad = 1'b0; expPcStall = 1'b0; expDecFlush = 1'b0; expExFlush = 1'b0;
            if (flushLeft > 0) begin
                expDecFlush = 1'b1;
                expExFlush  = 1'b1;
            end else if (branchTaken) begin
                expLoad     = 1'b1;
                expDecFlush = 1'b1;
                expExFlush  = 1'b1;
            end else if (modelLoadUse()) begin
                expPcStall = 1'b1;
                expExFlush = 1'b1;
            end
            checkOutput("pcStall", 32'(pcStall), 32'(expPcStall));
            checkOutput("pcLoad", 32'(pcLoad), 32'(expLoad));
            checkOutput("pcNext", 32'(pcNext), 32'(branchTarget));
            checkOutput("decodeStall", 32'(decodeStall), 32'(expPcStall));
            checkOutput("decodeFlush", 32'(decodeFlush), 32'(expDecFlush));
            checkOutput("executeFlush", 32'(executeFlush), 32'(expExFlush));
            checkOutput("forwardRs1Sel", 32'(forwardRs1Sel), 32'(mSel1));
            checkOutput("forwardRs2Sel", 32'(forwardRs2Sel), 32'(mSel2));
            checkOutput("stallCount", 32'(stallCount), 32'(mStall));
            checkOutput("flushCount", 32'(flushCount), 32'(mFlush));
        end
    end

    // ---------------- stimulus ----------------
    task automatic clearInputs();
        decodeRs1Addr    = 5'd0;
        decodeRs2Addr    = 5'd0;
        decodeRs1Used    = 1'b0;
        decodeRs2Used    = 1'b0;
        exRdAddr         = 5'd0;
        exRdWriteEnable  = 1'b0;
        exIsLoad         = 1'b0;
        memRdAddr        = 5'd0;
        memRdWriteEnable = 1'b0;
        branchTaken      = 1'b0;
        branchTarget     = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive a load in execute writing rd, read by decode rs1.
    task automatic applyStimulus(input logic [4:0] rd, input logic [4:0] rs1);
        exRdAddr        = rd;
        exRdWriteEnable = 1'b1;
        exIsLoad        = 1'b1;
        decodeRs1Addr   = rs1;
        decodeRs1Used   = 1'b1;
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checkOutput("reset_stallCount", 32'(stallCount), 32'd0);
        checkOutput("reset_flushCount", 32'(flushCount), 32'd0);
        checkOutput("reset_fwd1", 32'(forwardRs1Sel), 32'd0);
        checkOutput("reset_pcStall", 32'(pcStall), 32'd0);

        // Load-use on rs1 = x5: one stall cycle, then forward from writeback.
        applyStimulus(5'd5, 5'd5);
        #1;
        checkOutput("lu_pcStall", 32'(pcStall), 32'd1);
        step();
        checkOutput("lu_stallCount", 32'(stallCount), 32'd1);
        exRdWriteEnable  = 1'b0;
        exIsLoad         = 1'b0;
        memRdAddr        = 5'd5;
        memRdWriteEnable = 1'b1;
        #1;
        checkOutput("lu_release", 32'(pcStall), 32'd0);
        step();
        checkOutput("lu_fwd1", 32'(forwardRs1Sel), 32'd2);

        // Load writing x0 read as x0: never a hazard, never forwarded.
        clearInputs();
        applyStimulus(5'd0, 5'd0);
        #1;
        checkOutput("x0_pcStall", 32'(pcStall), 32'd0);
        step();
        checkOutput("x0_fwd1", 32'(forwardRs1Sel), 32'd0);

        // Taken branch with a 3-cycle shadow; load-use during FLUSH is ignored.
        clearInputs();
        branchTaken  = 1'b1;
        branchTarget = 30'h40;
        #1;
        checkOutput("br_pcLoad", 32'(pcLoad), 32'd1);
        checkOutput("br_pcNext", 32'(pcNext), 32'h40);
        step();
        branchTaken = 1'b0;
        applyStimulus(5'd5, 5'd5);
        #1;
        checkOutput("br_shadow1_flush", 32'(decodeFlush), 32'd1);
        checkOutput("br_shadow1_noStall", 32'(pcStall), 32'd0);
        step();
        checkOutput("br_shadow2_flush", 32'(decodeFlush), 32'd1);
        clearInputs();
        step();
        checkOutput("br_back_to_run", 32'(decodeFlush), 32'd0);
        checkOutput("br_flushCount", 32'(flushCount), 32'd1);
        checkOutput("br_stallCount", 32'(stallCount), 32'd1);

        // Branch and load-use together: the branch wins.
        applyStimulus(5'd9, 5'd9);
        branchTaken = 1'b1;
        #1;
        checkOutput("both_pcStall", 32'(pcStall), 32'd0);
        checkOutput("both_pcLoad", 32'(pcLoad), 32'd1);
        step();
        checkOutput("both_stallCount", 32'(stallCount), 32'd1);
        checkOutput("both_flushCount", 32'(flushCount), 32'd2);
        clearInputs();
        step();
        step();

        // Execute and memory both write x7; rs2 takes the younger execute result.
        exRdAddr         = 5'd7;
        exRdWriteEnable  = 1'b1;
        memRdAddr        = 5'd7;
        memRdWriteEnable = 1'b1;
        decodeRs2Addr    = 5'd7;
        decodeRs2Used    = 1'b1;
        step();
        checkOutput("x7_fwd2", 32'(forwardRs2Sel), 32'd1);

        // Reset in the middle of a branch shadow returns straight to RUN.
        clearInputs();
        branchTaken = 1'b1;
        step();
        branchTaken = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_flush", 32'(decodeFlush), 32'd0);
        checkOutput("rst_mid_flushCount", 32'(flushCount), 32'd0);

        // 2^PERF_W + 3 stall cycles saturate the stall counter.
        applyStimulus(5'd3, 5'd3);
        for (int i = 0; i < (1 << PERF_W) + 3; i++) begin
            step();
        end
        checkOutput("sat_stallCount", 32'(stallCount), 32'(PERF_SAT));
        clearInputs();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, errCount);
        $finish;
    end

endmodule
